// File: rtl/multicycle_control_if.sv
// Shared types and the control/datapath interface for the multicycle core.
//
// multicycle_pkg        : ALU operation encoding (alu_oper_type).
// multicycle_control_if : instruction fields, ALU/memory status in; datapath
//                         strobes, mux selects, ALU op and debug state out.
//   master modport : the control FSM (multicycle_control)
//   slave  modport : the datapath / integration side
package multicycle_pkg;
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_NOR  = 3'd4,
        ALU_SLT  = 3'd5,
        ALU_SLTU = 3'd6
    } alu_oper_type;
endpackage

interface multicycle_control_if #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
);
    import multicycle_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               alu_zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_write;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    alu_oper_type       alu_sel;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               illegal_instr;
    logic [3:0]         state_dbg;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
               mem_to_reg, illegal_instr, state_dbg
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
               mem_to_reg, illegal_instr, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the ALU operation.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (state -> IDLE, strobes drop at once)
//   bus   : multicycle_control_if.master (opcode/funct/alu_zero/mem_ready in,
//           control outputs and state_dbg out)
//
// Per-state outputs are registered from the next state, so they are glitch
// free and clear asynchronously on reset. The only combinational terms are
// ir_write/pc_write, which must follow mem_ready (FETCH) and alu_zero
// (BRANCH) within the same cycle.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.master  bus
);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(6'h20);
    localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(6'h22);
    localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'h24);
    localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'h25);
    localparam logic [FUNCT_W-1:0] F_NOR  = FUNCT_W'(6'h27);
    localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'h2A);
    localparam logic [FUNCT_W-1:0] F_SLTU = FUNCT_W'(6'h2B);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
        MEMRD   = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
        ALUWB   = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
        JUMP    = 4'd12, ILLEGAL = 4'd13
    } state_t;

    // fetch_wr / br_wr / jmp_wr are the unqualified sources of ir_write and
    // pc_write; the qualification with mem_ready/alu_zero happens below.
    typedef struct packed {
        logic         mem_req;
        logic         mem_write;
        logic         iord;
        logic [1:0]   pc_src;
        logic         alu_src_a;
        logic [1:0]   alu_src_b;
        alu_oper_type alu_sel;
        logic         reg_write;
        logic         reg_dst;
        logic         mem_to_reg;
        logic         illegal;
        logic         fetch_wr;
        logic         br_wr;
        logic         jmp_wr;
    } ctrl_t;

    state_t       state, nxt;
    ctrl_t        ctrl;
    alu_oper_type funct_sel;
    logic         funct_ok;

    function automatic ctrl_t ctrl_for(state_t s, alu_oper_type rsel);
        ctrl_t c;
        c = '0;
        c.alu_sel = ALU_ADD;
        case (s)
            FETCH:   begin c.mem_req = 1'b1; c.alu_src_b = 2'd1; c.fetch_wr = 1'b1; end
            DECODE:  c.alu_src_b = 2'd3;
            MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
            MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:   begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC:    begin c.alu_src_a = 1'b1; c.alu_sel = rsel; end
            ALUWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH:  begin
                c.alu_src_a = 1'b1; c.alu_sel = ALU_SUB;
                c.pc_src = 2'd1; c.br_wr = 1'b1;
            end
            ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            ADDIWB:  c.reg_write = 1'b1;
            JUMP:    begin c.pc_src = 2'd2; c.jmp_wr = 1'b1; end
            ILLEGAL: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        funct_ok  = 1'b1;
        funct_sel = ALU_ADD;
        case (bus.funct)
            F_ADD:   funct_sel = ALU_ADD;
            F_SUB:   funct_sel = ALU_SUB;
            F_AND:   funct_sel = ALU_AND;
            F_OR:    funct_sel = ALU_OR;
            F_NOR:   funct_sel = ALU_NOR;
            F_SLT:   funct_sel = ALU_SLT;
            F_SLTU:  funct_sel = ALU_SLTU;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = FETCH;
            FETCH:   if (bus.mem_ready) nxt = DECODE;
            DECODE:
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = ILLEGAL;
                endcase
            // Only lw/sw reach MEMADR, so anything but lw is a store.
            MEMADR:  nxt = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (bus.mem_ready) nxt = MEMWB;
            MEMWR:   if (bus.mem_ready) nxt = FETCH;
            EXEC:    nxt = funct_ok ? ALUWB : ILLEGAL;
            ADDIEX:  nxt = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, ILLEGAL: nxt = FETCH;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ctrl  <= '0;
        end else begin
            state <= nxt;
            ctrl  <= ctrl_for(nxt, funct_sel);
        end
    end

    assign bus.mem_req       = ctrl.mem_req;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.iord          = ctrl.iord;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_sel       = ctrl.alu_sel;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.illegal_instr = ctrl.illegal;
    assign bus.ir_write      = ctrl.fetch_wr & bus.mem_ready;
    assign bus.pc_write      = (ctrl.fetch_wr & bus.mem_ready)
                             | (ctrl.br_wr & bus.alu_zero)
                             | ctrl.jmp_wr;
    assign bus.state_dbg     = state;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the cessie datapath; sits directly upstream of the ALU.
- Decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the ALU operation select (alu_oper_type) and all datapath enables/muxes.
- Consumes the ALU zero flag for branches and a memory ready handshake for wait states.

Parameters:
- OP_W, 6, opcode field width
- FUNCT_W, 6, funct field width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  IR[31:26]
- funct  in  FUNCT_W  IR[5:0]
- alu_zero  in  1  high when ALU result == 0 (AND-reduction of the ALU zero bus done at integration)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_write  out  1  access is a write (valid with mem_req)
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- ir_write  out  1  load instruction register
- pc_write  out  1  PC load enable (already includes branch qualification)
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- alu_sel  out  alu_oper_type  ALU operation
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction
- state_dbg  out  4  current state encoding

Behaviour:
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, ILLEGAL=13
- Reset:
  - rst_n low forces state IDLE immediately.
  - In IDLE all strobes are 0: mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr.
  - In IDLE all mux selects are 0 and alu_sel = ALU_ADD.
- IDLE -> FETCH on the first rising clk edge after rst_n is released.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_sel=ALU_ADD, pc_src=0.
  - ir_write and pc_write are asserted only while mem_ready=1; state then goes to DECODE.
  - Otherwise the FSM stays in FETCH with the request held.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_sel=ALU_ADD (branch target precompute).
  - Next state by opcode: 0x23/0x2B -> MEMADR, 0x00 -> EXEC, 0x04 -> BRANCH, 0x08 -> ADDIEX, 0x02 -> JUMP, any other -> ILLEGAL.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_sel=ALU_ADD.
  - Next state: opcode 0x23 -> MEMRD, 0x2B -> MEMWR.
- MEMRD: mem_req=1, iord=1; hold until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; -> FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1; hold until mem_ready, then -> FETCH.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=0; alu_sel decoded from funct.
  - funct map: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - Next state: ALUWB for a mapped funct; any other funct -> ILLEGAL with no register write.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_sel=ALU_SUB, pc_src=1.
  - pc_write = alu_zero, combinational within the cycle; -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_sel=ALU_ADD; -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
- JUMP: pc_write=1, pc_src=2; -> FETCH.
- ILLEGAL: illegal_instr=1 for exactly one cycle; no writes; -> FETCH (instruction skipped, PC already advanced).
- Defaults: any output not listed for a state is 0 (alu_sel defaults to ALU_ADD).
- Handshake:
  - mem_req may not drop and iord/mem_write may not change while waiting for mem_ready.
  - mem_ready outside MEMRD/MEMWR/FETCH is ignored.
- Latencies with mem_ready always 1:
  - lw 5 cycles; sw, R-type and addi 4 cycles.
  - beq and j 3 cycles; illegal 3 cycles.
- Reset asserted mid-instruction: the FSM returns to IDLE asynchronously and all strobes drop in the same cycle; no partial writeback.
- state_dbg equals the state register encoding.

Test Plan:
- Reset then release, mem_ready=1 -> state_dbg 0 then 1; first FETCH asserts ir_write=1 and pc_write=1 with alu_sel=ALU_ADD, alu_src_b=1.
- R-type, opcode=0x00, funct=0x2A -> states 1,2,7,8; alu_sel=ALU_SLT in EXEC; reg_write=1, reg_dst=1 in ALUWB only.
- lw (0x23) with mem_ready held low 3 cycles in MEMRD -> mem_req=1, iord=1 for 4 cycles; MEMWB reg_write=1, mem_to_reg=1; total 8 cycles.
- beq (0x04) -> with alu_zero=1, pc_write=1 and pc_src=1 in BRANCH; repeated with alu_zero=0, pc_write=0; both return to FETCH.
- Undefined opcode 0x3F, then R-type with funct=0x01 -> illegal_instr pulses exactly one cycle each; reg_write, mem_write and pc_write stay 0 after DECODE.
- sw (0x2B) with rst_n pulled low while in MEMWR waiting on mem_ready -> mem_req and mem_write drop in the same cycle, state_dbg=0; after release the FSM restarts at FETCH.
